// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: in-order decoupling FIFO between the IF and ID stages.
// Each entry carries the PC, the instruction word and the IF-side exception
// fields. Head data is driven straight from storage, so an entry pushed on
// one edge becomes visible just after that edge; there is no bypass path.
module inst_fetch_buffer #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_allowin,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    input  logic             in_ex,
    input  logic [4:0]       in_exccode,
    input  logic [31:0]      in_badvaddr,
    input  logic             in_tlb_refill,
    input  logic             in_bd,

    output logic             out_valid,
    input  logic             out_allowin,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic             out_ex,
    output logic [4:0]       out_exccode,
    output logic [31:0]      out_badvaddr,
    output logic             out_tlb_refill,
    output logic             out_bd,

    output logic [PTR_W:0]   count
);

    localparam int unsigned CNT_W = PTR_W + 1;

    // One buffered instruction together with the exception state it carries.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic [4:0]  exccode;
        logic [31:0] badvaddr;
        logic        tlb_refill;
        logic        bd;
    } fetch_entry_t;

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    fetch_entry_t       w_in_entry;
    fetch_entry_t       w_head;

    // Occupancy flags and handshakes; allowin depends on state only, so a
    // full buffer refuses a push even when ID pops in the same cycle.
    always_comb begin
        w_full  = (r_count == CNT_W'(DEPTH));
        w_empty = (r_count == CNT_W'(0));
        w_push  = in_valid && !w_full;
        w_pop   = !w_empty && out_allowin;
    end

    // Pack the incoming fields into one storage word.
    always_comb begin
        w_in_entry            = '0;
        w_in_entry.pc         = in_pc;
        w_in_entry.inst       = in_inst;
        w_in_entry.ex         = in_ex;
        w_in_entry.exccode    = in_exccode;
        w_in_entry.badvaddr   = in_badvaddr;
        w_in_entry.tlb_refill = in_tlb_refill;
        w_in_entry.bd         = in_bd;
    end

    // Entry storage; not reset since pointers/count already mark it empty.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    // Pointer and occupancy state; flush discards concurrent push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Head entry, forced to zero while the buffer is empty.
    always_comb begin
        w_head = '0;
        if (!w_empty) begin
            w_head = r_mem[r_rd_ptr];
        end
    end

    // Drive the output ports from state.
    always_comb begin
        in_allowin     = !w_full;
        out_valid      = !w_empty;
        out_pc         = w_head.pc;
        out_inst       = w_head.inst;
        out_ex         = w_head.ex;
        out_exccode    = w_head.exccode;
        out_badvaddr   = w_head.badvaddr;
        out_tlb_refill = w_head.tlb_refill;
        out_bd         = w_head.bd;
        count          = r_count;
    end

    // Occupancy must stay within 0..DEPTH.
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        r_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Scoreboard bench for inst_fetch_buffer: a reference queue and occupancy
// model are updated on each clock edge and compared against the head of the
// DUT whenever the model says data should be present.
module tb_inst_fetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_allowin;
    logic [31:0]      in_pc;
    logic [31:0]      in_inst;
    logic             in_ex;
    logic [4:0]       in_exccode;
    logic [31:0]      in_badvaddr;
    logic             in_tlb_refill;
    logic             in_bd;
    logic             out_valid;
    logic             out_allowin;
    logic [31:0]      out_pc;
    logic [31:0]      out_inst;
    logic             out_ex;
    logic [4:0]       out_exccode;
    logic [31:0]      out_badvaddr;
    logic             out_tlb_refill;
    logic             out_bd;
    logic [PTR_W:0]   count;

    inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_allowin     (in_allowin),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .in_ex          (in_ex),
        .in_exccode     (in_exccode),
        .in_badvaddr    (in_badvaddr),
        .in_tlb_refill  (in_tlb_refill),
        .in_bd          (in_bd),
        .out_valid      (out_valid),
        .out_allowin    (out_allowin),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_ex         (out_ex),
        .out_exccode    (out_exccode),
        .out_badvaddr   (out_badvaddr),
        .out_tlb_refill (out_tlb_refill),
        .out_bd         (out_bd),
        .count          (count)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [103:0] sb_q[$];
    int           m_count = 0;
    int           max_count = 0;

    // Count a comparison and report any difference.
    task automatic check(input string tag, input logic [103:0] act, input logic [103:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Build an entry word with the given PC and random side fields.
    function automatic logic [103:0] mk(input logic [31:0] pc);
        logic [31:0] inst;
        logic [4:0]  code;
        logic [31:0] bva;
        logic [2:0]  flags;
        inst  = $urandom;
        code  = 5'($urandom_range(0, 31));
        bva   = $urandom;
        flags = 3'($urandom_range(0, 7));
        return {pc, inst, flags[0], code, bva, flags[1], flags[2]};
    endfunction

    // One clock: drive inputs, check at negedge, update the model at posedge.
    task automatic step(input logic v, input logic [103:0] e, input logic oa, input logic fl);
        logic m_push;
        logic m_pop;
        logic [103:0] head;
        in_valid      = v;
        {in_pc, in_inst, in_ex, in_exccode, in_badvaddr, in_tlb_refill, in_bd} = e;
        out_allowin   = oa;
        flush         = fl;
        @(negedge clk);
        head = {out_pc, out_inst, out_ex, out_exccode, out_badvaddr, out_tlb_refill, out_bd};
        check("out_valid", 104'(out_valid), 104'(m_count != 0));
        check("in_allowin", 104'(in_allowin), 104'(m_count != DEPTH));
        check("count", 104'(count), 104'(m_count));
        if (m_count != 0) check("head", head, sb_q[0]);
        else              check("head_zero", head, 104'(0));
        m_push = v && (m_count != DEPTH);
        m_pop  = (m_count != 0) && oa;
        @(posedge clk);
        if (fl) begin
            sb_q.delete();
            m_count = 0;
        end else begin
            if (m_pop) begin
                void'(sb_q.pop_front());
                m_count--;
            end
            if (m_push) begin
                sb_q.push_back(e);
                m_count++;
            end
        end
        if (m_count > max_count) max_count = m_count;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && m_count != 0; i++) step(1'b0, 104'(0), 1'b1, 1'b0);
    endtask

    initial begin
        logic [103:0] e;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_allowin = 1'b0;
        in_pc = '0; in_inst = '0; in_ex = 1'b0; in_exccode = '0;
        in_badvaddr = '0; in_tlb_refill = 1'b0; in_bd = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset.
        step(1'b0, 104'(0), 1'b0, 1'b0);
        check("reset_out_pc", 104'(out_pc), 104'(0));

        // Three pushes with ID stalled, then drain in order.
        for (int i = 0; i < 3; i++) step(1'b1, mk(32'hBFC0_0000 + 32'(i * 4)), 1'b0, 1'b0);
        check("three_count", 104'(count), 104'(3));
        check("three_head_pc", 104'(out_pc), 104'(32'hBFC0_0000));
        for (int i = 0; i < 3; i++) step(1'b0, 104'(0), 1'b1, 1'b0);
        check("three_drained", 104'(count), 104'(0));

        // Fill to DEPTH; further pushes refused until space exists.
        for (int i = 0; i < 4; i++) step(1'b1, mk(32'h0000_1000 + 32'(i * 4)), 1'b0, 1'b0);
        check("full_count", 104'(count), 104'(4));
        check("full_allowin", 104'(in_allowin), 104'(0));
        e = mk(32'h0000_2000);
        step(1'b1, e, 1'b0, 1'b0);
        check("full_refused", 104'(count), 104'(4));
        step(1'b1, e, 1'b1, 1'b0);
        check("full_push_pop", 104'(count), 104'(3));
        step(1'b1, e, 1'b1, 1'b0);
        check("push_pop_hold", 104'(count), 104'(3));
        drain();

        // Wrap-around: steady occupancy of two across pointer wrap.
        max_count = 0;
        for (int i = 0; i < 10; i++) step(1'b1, mk(32'h0040_0000 + 32'(i * 4)), m_count >= 2, 1'b0);
        drain();
        check("wrap_max", 104'(max_count <= DEPTH), 104'(1));

        // Exception fields travel unchanged.
        e = {32'h0000_0003, 32'h1234_5678, 1'b1, 5'h04, 32'h0000_0003, 1'b0, 1'b1};
        step(1'b1, e, 1'b0, 1'b0);
        check("exc_head", {out_pc, out_inst, out_ex, out_exccode, out_badvaddr, out_tlb_refill, out_bd}, e);
        drain();

        // Flush with a concurrent push.
        for (int i = 0; i < 3; i++) step(1'b1, mk(32'h0000_3000 + 32'(i * 4)), 1'b0, 1'b0);
        step(1'b1, mk(32'h0000_4000), 1'b0, 1'b1);
        check("flush_count", 104'(count), 104'(0));
        check("flush_valid", 104'(out_valid), 104'(0));
        step(1'b1, mk(32'h8000_0180), 1'b0, 1'b0);
        check("after_flush_pc", 104'(out_pc), 104'(32'h8000_0180));
        drain();

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 2; i++) step(1'b1, mk(32'h0000_5000 + 32'(i * 4)), 1'b0, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("async_rst_count", 104'(count), 104'(0));
        check("async_rst_valid", 104'(out_valid), 104'(0));
        sb_q.delete();
        m_count = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b1, mk(32'h0000_6000), 1'b0, 1'b0);
        step(1'b0, 104'(0), 1'b1, 1'b0);
        check("post_rst_empty", 104'(count), 104'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
